// File: rtl/regfile_op_sequencer.sv
// Command sequencer that owns the write port of an 8-entry register file and expands
// WRITE/CLEAR/COPY/SWAP commands into timed write pulses. Optional macro RFSEQ_LOCK_R0_EN
// write-protects register 0.
module regfile_op_sequencer #(
  parameter int DATA_W   = 4,
  parameter int ADDR_W   = 3,
  parameter int NUM_REGS = 8
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              cmd_valid,
  output logic              cmd_ready,
  input  logic [1:0]        cmd_op,
  input  logic [ADDR_W-1:0] cmd_a,
  input  logic [ADDR_W-1:0] cmd_b,
  input  logic [DATA_W-1:0] cmd_data,
  output logic              rf_we,
  output logic [ADDR_W-1:0] rf_w_adr,
  output logic [DATA_W-1:0] rf_din,
  output logic [ADDR_W-1:0] rf_r_adr,
  output logic [ADDR_W-1:0] rf_s_adr,
  input  logic [DATA_W-1:0] rf_r_data,
  input  logic [DATA_W-1:0] rf_s_data,
  output logic              busy,
  output logic              done
);

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_WR   = 3'd1,
    S_CLR  = 3'd2,
    S_CPY  = 3'd3,
    S_SWP1 = 3'd4,
    S_SWP2 = 3'd5,
    S_DONE = 3'd6
  } state_t;

  localparam logic [1:0] OP_WRITE = 2'b00;
  localparam logic [1:0] OP_CLEAR = 2'b01;
  localparam logic [1:0] OP_COPY  = 2'b10;

  // NUM_REGS is 2**ADDR_W, so an ADDR_W-bit counter reaches the last register exactly.
  localparam logic [ADDR_W-1:0] CNT_LAST = ADDR_W'(NUM_REGS - 1);

  state_t            state_q, state_d;
  logic [ADDR_W-1:0] a_q, a_d;
  logic [ADDR_W-1:0] b_q, b_d;
  logic [DATA_W-1:0] data_q, data_d;
  logic [ADDR_W-1:0] cnt_q, cnt_d;
  logic [DATA_W-1:0] tmp_q, tmp_d;

  logic              we_raw;
  logic [ADDR_W-1:0] w_adr_raw;
  logic [DATA_W-1:0] din_raw;
  logic              we_ok;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q <= S_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      data_q  <= '0;
      cnt_q   <= '0;
      tmp_q   <= '0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      data_q  <= data_d;
      cnt_q   <= cnt_d;
      tmp_q   <= tmp_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    a_d       = a_q;
    b_d       = b_q;
    data_d    = data_q;
    cnt_d     = cnt_q;
    tmp_d     = tmp_q;
    we_raw    = 1'b0;
    w_adr_raw = '0;
    din_raw   = '0;
    rf_r_adr  = '0;
    rf_s_adr  = '0;
    cmd_ready = 1'b0;
    busy      = 1'b1;
    done      = 1'b0;

    case (state_q)
      S_IDLE: begin
        cmd_ready = 1'b1;
        busy      = 1'b0;
        if (cmd_valid) begin
          a_d    = cmd_a;
          b_d    = cmd_b;
          data_d = cmd_data;
          cnt_d  = '0;
          case (cmd_op)
            OP_WRITE: state_d = S_WR;
            OP_CLEAR: state_d = S_CLR;
            OP_COPY:  state_d = S_CPY;
            default:  state_d = S_SWP1;
          endcase
        end
      end

      S_WR: begin
        we_raw    = 1'b1;
        w_adr_raw = a_q;
        din_raw   = data_q;
        state_d   = S_DONE;
      end

      S_CLR: begin
        we_raw    = 1'b1;
        w_adr_raw = cnt_q;
        if (cnt_q == CNT_LAST) begin
          state_d = S_DONE;
        end else begin
          cnt_d = cnt_q + ADDR_W'(1);
        end
      end

      S_CPY: begin
        rf_r_adr = a_q;
        if (a_q != b_q) begin
          we_raw    = 1'b1;
          w_adr_raw = b_q;
          din_raw   = rf_r_data;
        end
        state_d = S_DONE;
      end

      // A self-swap degenerates to a single idle op cycle with no write.
      S_SWP1: begin
        rf_r_adr = a_q;
        rf_s_adr = b_q;
        if (a_q != b_q) begin
          tmp_d     = rf_r_data;
          we_raw    = 1'b1;
          w_adr_raw = a_q;
          din_raw   = rf_s_data;
          state_d   = S_SWP2;
        end else begin
          state_d = S_DONE;
        end
      end

      S_SWP2: begin
        we_raw    = 1'b1;
        w_adr_raw = b_q;
        din_raw   = tmp_q;
        state_d   = S_DONE;
      end

      S_DONE: begin
        done    = 1'b1;
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

`ifdef RFSEQ_LOCK_R0_EN
  assign we_ok = we_raw && (w_adr_raw != '0);
`else
  assign we_ok = we_raw;
`endif

  // Address and data buses are parked at zero whenever no write is issued.
  assign rf_we    = we_ok;
  assign rf_w_adr = we_ok ? w_adr_raw : '0;
  assign rf_din   = we_ok ? din_raw : '0;

endmodule
